// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register-file write port, requester 0 over requester 1, with an r1 starvation guard.
// Latency: grant is combinational; the winning write reaches rf_wr_* on the next clk edge. Optional counters: REGFILE_ARB_STATS_EN.
// Backpressure: the loser sees ready low and must hold valid/addr/data; nothing is buffered here.
module regfile_wr_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              r0_valid,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  output logic              r0_ready,
  input  logic              r1_valid,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              r1_ready,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              r1_forced
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [15:0]       r0_grant_cnt,
  output logic [15:0]       r1_grant_cnt,
  output logic [15:0]       forced_cnt
`endif
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;
  logic             r0_xfer;
  logic             r1_xfer;

  // Grants are also blocked while reset is held low.
  always_comb begin
    r1_forced = (wait_cnt == WAIT_MAX);
    r0_ready  = 1'b0;
    r1_ready  = 1'b0;
    if (rst && !flush) begin
      if (r1_forced) begin
        r1_ready = r1_valid;
      end else begin
        r0_ready = r0_valid;
        r1_ready = r1_valid & ~r0_valid;
      end
    end
  end

  assign r0_xfer = r0_valid & r0_ready;
  assign r1_xfer = r1_valid & r1_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (flush || !r1_valid || r1_xfer) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else begin
      rf_wr_en <= r0_xfer | r1_xfer;
      if (r0_xfer) begin
        rf_wr_addr <= r0_addr;
        rf_wr_data <= r0_data;
      end else if (r1_xfer) begin
        rf_wr_addr <= r1_addr;
        rf_wr_data <= r1_data;
      end
    end
  end

`ifdef REGFILE_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r0_grant_cnt <= '0;
      r1_grant_cnt <= '0;
      forced_cnt   <= '0;
    end else begin
      if (r0_xfer && r0_grant_cnt != 16'hFFFF) begin
        r0_grant_cnt <= r0_grant_cnt + 16'd1;
      end
      if (r1_xfer && r1_grant_cnt != 16'hFFFF) begin
        r1_grant_cnt <= r1_grant_cnt + 16'd1;
      end
      if (r1_xfer && r1_forced && forced_cnt != 16'hFFFF) begin
        forced_cnt <= forced_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
